axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter: LINE_WORDS, default 4, number of 32-bit beats in one cache-line burst.
REQ-002 clk  input  1  single core clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_rd_req / d_rd_req  input  1  icache / dcache read request.
REQ-005 i_rd_type / d_rd_type  input  3  request type: 000 byte, 001 half, 010 word, 100 cache line.
REQ-006 i_rd_addr / d_rd_addr  input  32  request address.
REQ-007 i_rd_rdy / d_rd_rdy  output  1  request accepted this cycle when rd_req & rd_rdy.
REQ-008 i_ret_valid / d_ret_valid  output  1  return beat valid for that requester.
REQ-009 i_ret_last / d_ret_last  output  1  final beat of the return.
REQ-010 i_ret_data / d_ret_data  output  32  return beat data.
REQ-011 arid  output  4; araddr  output  32; arlen  output  8; arsize  output  3; arburst  output  2: AXI read-address fields.
REQ-012 arvalid  output  1; arready  input  1: AXI read-address handshake.
REQ-013 rid  input  4; rdata  input  32; rresp  input  2; rlast  input  1; rvalid  input  1; rready  output  1: AXI read-data channel.

Function
REQ-014 Three-state FSM:
- IDLE -> AR on an accepted request.
- AR -> R on arvalid & arready.
- R -> IDLE on rvalid & rready & rlast.
REQ-015 At most one read is outstanding at a time.
REQ-016 In IDLE, rd_rdy is combinational and asserted only to the arbitration winner among the asserted rd_req; both rd_rdy are 0 in AR and R.
REQ-017 Round-robin arbitration:
- Single requester: that requester wins.
- Both requesting: the requester not granted last wins.
- last_grant updates on each acceptance.
REQ-018 On acceptance, register the following for the whole transaction: owner, address, type.
REQ-019 arvalid is 1 in AR only (first cycle of AR is the cycle after acceptance); araddr, arid, arlen and arsize are held stable until arready.
REQ-020 arid = 0 for icache, 1 for dcache.
REQ-021 arburst = 01 (INCR).
REQ-022 arlen = LINE_WORDS-1 for type 100, otherwise 0.
REQ-023 arsize = 010 for types 010 and 100, 000 for 000, 001 for 001.
REQ-024 rready = 1 in R only; rvalid outside R is ignored.
REQ-025 In R, each rvalid beat with rid equal to the stored id is forwarded combinationally, same cycle, to the owner only:
- ret_valid = 1
- ret_data = rdata
- ret_last = rlast
REQ-026 A beat whose rid mismatches is consumed and dropped; the non-owner's ret_valid stays 0.
REQ-027 rresp is ignored.
REQ-028 A beat counter counts accepted beats; it clears on entry to R.
REQ-029 Completion is taken from rlast; the counter does not gate completion. The counter is for assertion/debug only (expected count = arlen+1).
REQ-030 A request arriving during AR or R is held off (rd_rdy = 0) and is granted on the first IDLE cycle.
REQ-031 Return to IDLE and a new grant may not occur in the same cycle; minimum one IDLE cycle between transactions.

Reset
REQ-032 Reset drives the following within the same cycle:
- FSM to IDLE
- arvalid, rready, all rd_rdy, all ret_valid and all ret_last to 0
- beat counter to 0
- last_grant to dcache, so icache wins the first tie
- stored address/type/owner to 0
REQ-033 Reset mid-transaction abandons the burst; no ret_valid is produced for it after reset deasserts.

Structure
REQ-034 A shared package holds:
- rd_type encodings
- AXI burst/size constants
- requester ID constants
- FSM state enumeration
REQ-035 One sub-module is natural: rr_arb2, a two-requester round-robin arbiter with grant-update input; everything else is inline.

Verification
REQ-036 Single line fetch: i_rd_req, type 100, addr 0x1C000000.
- Response: arid 0, arlen 3, arsize 010, arburst 01.
- Four beats reach i_ret_data; i_ret_last only on the 4th.
- d_ret_valid stays 0.
REQ-037 Simultaneous i_rd_req and d_rd_req after reset.
- icache granted first; dcache granted in the first IDLE after icache rlast.
- A following tie grants dcache first.
REQ-038 Dcache word read, type 010, addr 0x8000_0004.
- Response: arid 1, arlen 0, arsize 010.
- One beat with d_ret_last=1.
REQ-039 arready held 0 for 5 cycles.
- arvalid and all AR fields stable for all 5 cycles.
- No rd_rdy asserted.
REQ-040 Reset asserted after the 2nd beat of a line burst.
- arvalid, rready and ret_valid are 0 immediately.
- After deassertion, a new icache request is granted from IDLE.
REQ-041 Byte and half reads (types 000, 001) produce arsize 000 and 001 with arlen 0.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the icache/dcache AXI read arbiter:
//   - request type encodings carried on rd_type
//   - AXI burst/size constants driven on the AR channel
//   - AXI IDs assigned to each requester
//   - arbiter FSM state enumeration
//   - helper that maps a request type onto an AXI beat size
package axi_rd_arbiter_pkg;

    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_1B    = 3'b000;
    localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    localparam logic [3:0] ID_ICACHE = 4'd0;
    localparam logic [3:0] ID_DCACHE = 4'd1;

    // Bit positions of each requester in req/grant vectors.
    localparam int unsigned REQ_I = 0;
    localparam int unsigned REQ_D = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R
    } arb_state_t;

    // Word and line requests both move 32-bit beats; unknown encodings
    // are treated as word reads.
    function automatic logic [2:0] arsize_for(input logic [2:0] rd_type);
        case (rd_type)
            RD_TYPE_BYTE: return AXI_SIZE_1B;
            RD_TYPE_HALF: return AXI_SIZE_2B;
            default:      return AXI_SIZE_4B;
        endcase
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Bus interfaces for the AXI read arbiter.
//   axi_rd_arbiter_cache_if : one cache read port (request + return beats)
//     master = cache side, slave = arbiter side
//     rd_req/rd_type/rd_addr  request, accepted when rd_req & rd_rdy
//     ret_valid/ret_last/ret_data  return beats towards the cache
//   axi_rd_arbiter_if : AXI read-address and read-data channels
//     master = arbiter side, slave = memory side
interface axi_rd_arbiter_cache_if;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;

    modport master (
        output rd_req, rd_type, rd_addr,
        input  rd_rdy, ret_valid, ret_last, ret_data
    );

    modport slave (
        input  rd_req, rd_type, rd_addr,
        output rd_rdy, ret_valid, ret_last, ret_data
    );
endinterface

interface axi_rd_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, reset : core clock, asynchronous active-high reset
//   req[1:0]   : request vector (bit REQ_I = icache, bit REQ_D = dcache)
//   update     : grant was taken this cycle; remember who won
//   grant[1:0] : combinational one-hot grant (all zero when no request)
module rr_arb2
    import axi_rd_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // 1 = dcache was granted last. Resets to dcache so icache wins the
    // first tie.
    logic last_grant_d;

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant[REQ_I] = 1'b1;
            2'b10:   grant[REQ_D] = 1'b1;
            2'b11: begin
                if (last_grant_d) grant[REQ_I] = 1'b1;
                else              grant[REQ_D] = 1'b1;
            end
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant_d <= 1'b1;
        else if (update && (|grant))
            last_grant_d <= grant[REQ_D];
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read port between an icache and a dcache.
// One read is outstanding at a time; IDLE -> AR -> R -> IDLE.
//   clk, reset : core clock, asynchronous active-high reset
//   icache     : icache read port (slave side)
//   dcache     : dcache read port (slave side)
//   axi        : AXI AR/R channels (master side)
//   LINE_WORDS : 32-bit beats per cache-line burst
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    axi_rd_arbiter_cache_if.slave  icache,
    axi_rd_arbiter_cache_if.slave  dcache,
    axi_rd_arbiter_if.master       axi
);

    arb_state_t  state, state_nxt;
    logic [1:0]  req, grant, rdy;
    logic        accept;

    // Transaction context captured on acceptance (owner 1 = dcache).
    logic        owner_q;
    logic [31:0] addr_q;
    logic [2:0]  type_q;

    logic [3:0]  id_q;
    logic [7:0]  arlen_q;
    logic        fwd;
    logic [7:0]  beat_cnt;

    assign req = {dcache.rd_req, icache.rd_req};

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .update (accept),
        .grant  (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Grants only come out of IDLE, so completion in R and the next grant
    // can never share a cycle.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        rdy         = '0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!reset) begin
                    rdy    = grant;
                    accept = |grant;
                end
                if (accept) state_nxt = ST_AR;
            end
            ST_AR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) state_nxt = ST_R;
            end
            ST_R: begin
                axi.rready = 1'b1;
                if (axi.rvalid && axi.rlast) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign icache.rd_rdy = rdy[REQ_I];
    assign dcache.rd_rdy = rdy[REQ_D];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= 1'b0;
            addr_q  <= '0;
            type_q  <= '0;
        end else if (accept) begin
            owner_q <= grant[REQ_D];
            addr_q  <= grant[REQ_D] ? dcache.rd_addr : icache.rd_addr;
            type_q  <= grant[REQ_D] ? dcache.rd_type : icache.rd_type;
        end
    end

    assign id_q    = owner_q ? ID_DCACHE : ID_ICACHE;
    assign arlen_q = (type_q == RD_TYPE_LINE) ? 8'(LINE_WORDS - 1) : '0;

    assign axi.arid    = id_q;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = arsize_for(type_q);
    assign axi.arburst = AXI_BURST_INCR;

    // Beats with a foreign rid are still consumed (rready is 1) but never
    // reach either cache.
    assign fwd = axi.rready && axi.rvalid && (axi.rid == id_q);

    assign icache.ret_valid = fwd && !owner_q;
    assign icache.ret_last  = fwd && !owner_q && axi.rlast;
    assign icache.ret_data  = (fwd && !owner_q) ? axi.rdata : '0;
    assign dcache.ret_valid = fwd && owner_q;
    assign dcache.ret_last  = fwd && owner_q && axi.rlast;
    assign dcache.ret_data  = (fwd && owner_q) ? axi.rdata : '0;

    // Debug beat counter: completion is decided by rlast alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            beat_cnt <= '0;
        else if (state == ST_AR && axi.arready)
            beat_cnt <= '0;
        else if (fwd)
            beat_cnt <= beat_cnt + 8'd1;
    end

    a_beat_count: assert property (@(posedge clk) disable iff (reset)
        (fwd && axi.rlast) |-> (beat_cnt == arlen_q));

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

    logic clk;
    logic reset;

    axi_rd_arbiter_cache_if ic_if ();
    axi_rd_arbiter_cache_if dc_if ();
    axi_rd_arbiter_if       axi_if ();

    axi_rd_arbiter #(.LINE_WORDS(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .icache (ic_if),
        .dcache (dc_if),
        .axi    (axi_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        i_req;
        logic [2:0]  i_type;
        logic [31:0] i_addr;
        logic        d_req;
        logic [2:0]  d_type;
        logic [31:0] d_addr;
        logic        arready;
        logic        rvalid;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic        rlast;
        logic        e_i_rdy;
        logic        e_d_rdy;
        logic        e_arvalid;
        logic [31:0] e_araddr;
        logic [3:0]  e_arid;
        logic [7:0]  e_arlen;
        logic [2:0]  e_arsize;
        logic        e_rready;
        logic        e_i_vld;
        logic        e_i_last;
        logic [31:0] e_i_data;
        logic        e_d_vld;
        logic        e_d_last;
        logic [31:0] e_d_data;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t ireq(vec_t v, logic [2:0] t, logic [31:0] a);
        v.i_req = 1'b1; v.i_type = t; v.i_addr = a;
        return v;
    endfunction

    function automatic vec_t dreq(vec_t v, logic [2:0] t, logic [31:0] a);
        v.d_req = 1'b1; v.d_type = t; v.d_addr = a;
        return v;
    endfunction

    function automatic vec_t ar(vec_t v, logic ready, logic [31:0] a, logic [3:0] id,
                                logic [7:0] len, logic [2:0] size);
        v.arready = ready; v.e_arvalid = 1'b1; v.e_araddr = a;
        v.e_arid = id; v.e_arlen = len; v.e_arsize = size;
        return v;
    endfunction

    function automatic vec_t beat(vec_t v, logic [3:0] id, logic [31:0] d, logic last);
        v.rvalid = 1'b1; v.rid = id; v.rdata = d; v.rlast = last; v.e_rready = 1'b1;
        return v;
    endfunction

    function automatic vec_t ret_i(vec_t v, logic [31:0] d, logic last);
        v.e_i_vld = 1'b1; v.e_i_data = d; v.e_i_last = last;
        return v;
    endfunction

    function automatic vec_t ret_d(vec_t v, logic [31:0] d, logic last);
        v.e_d_vld = 1'b1; v.e_d_data = d; v.e_d_last = last;
        return v;
    endfunction

    // Drive one cycle of inputs just after the rising edge, compare late in
    // the same cycle, then move on to just after the next rising edge.
    task automatic run_vec(input vec_t v, input string name);
        bit ok;
        reset            = v.rst;
        ic_if.rd_req     = v.i_req;
        ic_if.rd_type    = v.i_type;
        ic_if.rd_addr    = v.i_addr;
        dc_if.rd_req     = v.d_req;
        dc_if.rd_type    = v.d_type;
        dc_if.rd_addr    = v.d_addr;
        axi_if.arready   = v.arready;
        axi_if.rvalid    = v.rvalid;
        axi_if.rid       = v.rid;
        axi_if.rdata     = v.rdata;
        axi_if.rlast     = v.rlast;
        axi_if.rresp     = 2'b10;
        #3;
        n_vec++;
        ok = (ic_if.rd_rdy === v.e_i_rdy) && (dc_if.rd_rdy === v.e_d_rdy) &&
             (axi_if.arvalid === v.e_arvalid) && (axi_if.rready === v.e_rready) &&
             (ic_if.ret_valid === v.e_i_vld) && (ic_if.ret_last === v.e_i_last) &&
             (dc_if.ret_valid === v.e_d_vld) && (dc_if.ret_last === v.e_d_last);
        if (v.e_arvalid)
            ok = ok && (axi_if.araddr === v.e_araddr) && (axi_if.arid === v.e_arid) &&
                 (axi_if.arlen === v.e_arlen) && (axi_if.arsize === v.e_arsize) &&
                 (axi_if.arburst === 2'b01);
        if (v.e_i_vld) ok = ok && (ic_if.ret_data === v.e_i_data);
        if (v.e_d_vld) ok = ok && (dc_if.ret_data === v.e_d_data);
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got rdy=%b%b arv=%b ar=%h/%h/%h/%h/%h rready=%b i=%b%b/%h d=%b%b/%h ; want rdy=%b%b arv=%b ar=%h/%h/%h/%h/01 rready=%b i=%b%b/%h d=%b%b/%h",
                     name, ic_if.rd_rdy, dc_if.rd_rdy, axi_if.arvalid, axi_if.araddr,
                     axi_if.arid, axi_if.arlen, axi_if.arsize, axi_if.arburst, axi_if.rready,
                     ic_if.ret_valid, ic_if.ret_last, ic_if.ret_data,
                     dc_if.ret_valid, dc_if.ret_last, dc_if.ret_data,
                     v.e_i_rdy, v.e_d_rdy, v.e_arvalid, v.e_araddr, v.e_arid, v.e_arlen,
                     v.e_arsize, v.e_rready, v.e_i_vld, v.e_i_last, v.e_i_data,
                     v.e_d_vld, v.e_d_last, v.e_d_data);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        reset = 1'b0;
        ic_if.rd_req = 1'b0; ic_if.rd_type = '0; ic_if.rd_addr = '0;
        dc_if.rd_req = 1'b0; dc_if.rd_type = '0; dc_if.rd_addr = '0;
        axi_if.arready = 1'b0; axi_if.rvalid = 1'b0; axi_if.rid = '0;
        axi_if.rdata = '0; axi_if.rlast = 1'b0; axi_if.rresp = '0;
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state: requests present but nothing granted or valid.
        v = '0; v.rst = 1'b1; v = ireq(v, 3'b100, 32'h1C00_0000);
        v = dreq(v, 3'b010, 32'h8000_0004);
        run_vec(v, "reset_state");

        // ---- table: ties, word/half/byte reads, dropped beat, stray rvalid ----
        v = '0; tbl.push_back(v);
        v = '0; v = ireq(v, 3'b010, 32'h0000_0100); v = dreq(v, 3'b010, 32'h8000_0004);
        v.e_i_rdy = 1'b1; tbl.push_back(v);
        v = '0; v = dreq(v, 3'b010, 32'h8000_0004);
        v = ar(v, 1'b1, 32'h0000_0100, 4'd0, 8'd0, 3'b010); tbl.push_back(v);
        v = '0; v = dreq(v, 3'b010, 32'h8000_0004);
        v = beat(v, 4'd0, 32'hA5A5_A5A5, 1'b1); v = ret_i(v, 32'hA5A5_A5A5, 1'b1); tbl.push_back(v);
        v = '0; v = ireq(v, 3'b001, 32'h0000_0102); v = dreq(v, 3'b010, 32'h8000_0004);
        v.e_d_rdy = 1'b1; tbl.push_back(v);
        v = '0; v = ireq(v, 3'b001, 32'h0000_0102);
        v = ar(v, 1'b1, 32'h8000_0004, 4'd1, 8'd0, 3'b010); tbl.push_back(v);
        v = '0; v = ireq(v, 3'b001, 32'h0000_0102);
        v = beat(v, 4'd1, 32'hDEAD_BEEF, 1'b1); v = ret_d(v, 32'hDEAD_BEEF, 1'b1); tbl.push_back(v);
        v = '0; v = ireq(v, 3'b001, 32'h0000_0102); v.e_i_rdy = 1'b1; tbl.push_back(v);
        v = '0; v = ar(v, 1'b1, 32'h0000_0102, 4'd0, 8'd0, 3'b001); tbl.push_back(v);
        v = '0; v = beat(v, 4'd1, 32'h1234_5678, 1'b0); tbl.push_back(v);
        v = '0; v = beat(v, 4'd0, 32'h0000_BEEF, 1'b1); v = ret_i(v, 32'h0000_BEEF, 1'b1); tbl.push_back(v);
        v = '0; v = ireq(v, 3'b000, 32'h0000_0103);
        v.rvalid = 1'b1; v.rlast = 1'b1; v.rdata = 32'h5555_5555; v.e_i_rdy = 1'b1; tbl.push_back(v);
        v = '0; v = ar(v, 1'b1, 32'h0000_0103, 4'd0, 8'd0, 3'b000); tbl.push_back(v);
        v = '0; v = beat(v, 4'd0, 32'h0000_00AB, 1'b1); v = ret_i(v, 32'h0000_00AB, 1'b1); tbl.push_back(v);
        v = '0; tbl.push_back(v);

        foreach (tbl[k]) run_vec(tbl[k], $sformatf("tbl%0d", k));

        // ---- line fetch with a 5-cycle arready stall, dcache waiting ----
        v = '0; v = ireq(v, 3'b100, 32'h1C00_0000); v.e_i_rdy = 1'b1;
        run_vec(v, "line_grant");
        for (int unsigned k = 0; k < 5; k++) begin
            v = '0; v = dreq(v, 3'b010, 32'h8000_0010);
            v = ar(v, 1'b0, 32'h1C00_0000, 4'd0, 8'd3, 3'b010);
            run_vec(v, $sformatf("ar_stall%0d", k));
        end
        v = '0; v = dreq(v, 3'b010, 32'h8000_0010);
        v = ar(v, 1'b1, 32'h1C00_0000, 4'd0, 8'd3, 3'b010);
        run_vec(v, "ar_accept");
        for (int unsigned k = 0; k < 4; k++) begin
            v = '0; v = dreq(v, 3'b010, 32'h8000_0010);
            v = beat(v, 4'd0, 32'h1000_0000 + k, k == 3);
            v = ret_i(v, 32'h1000_0000 + k, k == 3);
            run_vec(v, $sformatf("line_beat%0d", k));
        end
        v = '0; v = dreq(v, 3'b010, 32'h8000_0010); v.e_d_rdy = 1'b1;
        run_vec(v, "d_after_line");
        v = '0; v = ar(v, 1'b1, 32'h8000_0010, 4'd1, 8'd0, 3'b010);
        run_vec(v, "d_ar");
        v = '0; v = beat(v, 4'd1, 32'hCAFE_F00D, 1'b1); v = ret_d(v, 32'hCAFE_F00D, 1'b1);
        run_vec(v, "d_beat");

        // ---- reset after the 2nd beat of a line burst ----
        v = '0; v = ireq(v, 3'b100, 32'h1C00_0040); v.e_i_rdy = 1'b1;
        run_vec(v, "rst_grant");
        v = '0; v = ar(v, 1'b1, 32'h1C00_0040, 4'd0, 8'd3, 3'b010);
        run_vec(v, "rst_ar");
        for (int unsigned k = 0; k < 2; k++) begin
            v = '0; v = beat(v, 4'd0, 32'h2000_0000 + k, 1'b0);
            v = ret_i(v, 32'h2000_0000 + k, 1'b0);
            run_vec(v, $sformatf("rst_beat%0d", k));
        end
        v = '0; v.rst = 1'b1; v = ireq(v, 3'b100, 32'h1C00_0080);
        v.rvalid = 1'b1; v.rdata = 32'h2000_0002;
        run_vec(v, "rst_mid_burst");
        v = '0; v.rvalid = 1'b1; v.rlast = 1'b1; v.rdata = 32'h2000_0003;
        run_vec(v, "rst_abandoned_beat");
        v = '0; v = ireq(v, 3'b100, 32'h1C00_0080); v = dreq(v, 3'b010, 32'h8000_0020);
        v.e_i_rdy = 1'b1;
        run_vec(v, "rst_tie_icache");
        v = '0; v = ar(v, 1'b1, 32'h1C00_0080, 4'd0, 8'd3, 3'b010);
        run_vec(v, "rst_new_ar");
        for (int unsigned k = 0; k < 4; k++) begin
            v = '0; v = beat(v, 4'd0, 32'h3000_0000 + k, k == 3);
            v = ret_i(v, 32'h3000_0000 + k, k == 3);
            run_vec(v, $sformatf("rst_new_beat%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
